ext_intr_ctrl: RTL and testbench
================================

# ext_intr_ctrl

External interrupt controller: the requesting end of the core's `intr` / `cu_intr_ack` handshake. It synchronises up to `NSRC` asynchronous device lines, latches them into a pending register and masks them with an enable register. It picks the highest-priority enabled pending source, raises `intr`, and holds the claimed source ID until the handler signals completion on `mret`. It sits between the peripherals and the single-cycle core, which sets its MEIP pending bit from `intr`.

## Interface

Parameters:
- `NSRC`, 8: number of interrupt sources, 1..31.
- `IDW`, `$clog2(NSRC+1)`: ID width. ID 0 means "none"; source i reports ID i+1.

Ports:
- `clk`  in  1  core clock.
- `reset`  in  1  asynchronous, active-high reset.
- `irq_src`  in  NSRC  raw device interrupt lines, asynchronous to `clk`.
- `cfg_we`  in  1  register write strobe, one cycle.
- `cfg_addr`  in  2  register select: 0 = ENABLE, 1 = PENDING, 2 = CLAIM (read-only), 3 = reserved.
- `cfg_wdata`  in  32  write data; bits [NSRC-1:0] are used.
- `cfg_rdata`  out  32  combinational read of the register at `cfg_addr`; unused bits read 0.
- `intr`  out  1  interrupt request to the core; registered.
- `cu_intr_ack`  in  1  one-cycle claim acknowledge from the core.
- `intr_done`  in  1  one-cycle completion strobe, driven by `mret`.
- `intr_id`  out  IDW  ID of the request or claim currently in flight; 0 when idle.
- `busy`  out  1  high in the REQ and SERV states.

## Operation

- Each source passes through a 2-flop synchroniser and then into `pend[i]`.
- Eligible set: `elig = pend & en`.
- Arbitration: fixed priority, lowest index wins. It is evaluated only in IDLE.
- FSM states:
  - IDLE: `intr` = 0, `intr_id` = 0. If `elig` is non-zero, latch the winning ID and go to REQ.
  - REQ: `intr` = 1, `intr_id` holds the latched ID.
    - On `cu_intr_ack`: clear `pend[id-1]` (edge mode only) and go to SERV.
    - The request is never retracted. If the source's enable bit is cleared while in REQ, REQ still waits for the ack.
  - SERV: `intr` = 0, `intr_id` holds the ID. On `intr_done`, go to IDLE.
- Ignored events: `cu_intr_ack` outside REQ; `intr_done` outside SERV.
- ENABLE register: a write loads `en` from `cfg_wdata[NSRC-1:0]`.
- PENDING register: a write clears every `pend` bit that is written as 1 (W1C).
- CLAIM register: reads `intr_id` zero-extended; writes are ignored.
- Simultaneous events on the same bit in one cycle: a hardware set wins over an ack-clear and over a W1C clear.
- Reset mid-operation returns the block to IDLE immediately, with the request dropped.
- Reset values: `en` = 0, `pend` = 0, synchronisers = 0, state = IDLE, `intr` = 0, `intr_id` = 0, `busy` = 0.

## Timing

- A raw rising edge sampled at clock edge k produces:
  - `pend` set after edge k+2;
  - state REQ and `intr` = 1 after edge k+3.
- Ack sampled at edge a: `intr` = 0 and `pend` cleared after edge a.
- `intr_done` sampled at edge d: IDLE after edge d. The next request can assert after edge d+1.
- `intr` stays high continuously from REQ entry until the ack.
- Pulses shorter than one `clk` period are not guaranteed to be captured.

## Configuration

- `INTR_EDGE_EN` defined (edge mode):
  - `pend[i]` sets on a synchronised 0→1 transition of source i.
  - The bit clears on claim-ack or by W1C.
- `INTR_EDGE_EN` undefined (level mode):
  - `pend[i]` equals the synchronised level every cycle.
  - PENDING writes and ack-clears have no effect.
  - The handler must deassert the device before `mret`. After `intr_done`, a level that is still high re-requests from IDLE.

## Structure

- Package `intr_pkg` holds:
  - the state enum (IDLE, REQ, SERV);
  - the `cfg_addr` constants ENABLE / PENDING / CLAIM;
  - the priority-encoder function (index → ID, returning 0 when there is no eligible source).
- Sub-module `intr_sync`: one per source. It contains the 2-flop synchroniser, plus a delayed copy and a rise output when edge mode is compiled in.

## Test plan

- Edge mode. ENABLE = 0x01; pulse `irq_src[0]` for 2 cycles → `intr` = 1 exactly 3 edges later, `intr_id` = 1. Ack → `intr` = 0, PENDING = 0. `intr_done` → IDLE, `intr_id` = 0.
- ENABLE = 0xFF; raise sources 5 and 2 in the same cycle → `intr_id` = 3. After ack and done, `intr_id` = 6 follows.
- ENABLE = 0x00; pulse source 4 → PENDING reads 0x10 and `intr` stays 0. Write ENABLE = 0x10 → `intr` = 1 with `intr_id` = 5 two edges later.
- Same cycle: ack of source 1 and a new edge of source 1 → PENDING bit 0 stays 1, and source 1 re-requests after `intr_done`.
- Spurious strobes: `cu_intr_ack` in IDLE and `intr_done` in REQ → no state change.
- Reset asserted in SERV → `intr`, `intr_id`, `busy` and PENDING are all 0 immediately.
- Level mode (macro undefined): hold `irq_src[0]` high through `intr_done` → a second request with `intr_id` = 1 follows.

Source files
------------

// File: rtl/intr_pkg.sv
// ---------------------------------------------------------------------------
// intr_pkg
// Shared definitions for the external interrupt controller:
//   - state_t        : controller FSM states (IDLE, REQ, SERV)
//   - ADDR_*         : cfg_addr register selects
//   - prio_id()      : fixed-priority encoder, lowest index wins,
//                      returns source index + 1 or 0 when nothing is eligible
// No ports (package).
// ---------------------------------------------------------------------------
package intr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SERV = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_ENABLE  = 2'd0;
    localparam logic [1:0] ADDR_PENDING = 2'd1;
    localparam logic [1:0] ADDR_CLAIM   = 2'd2;

    // Scans from the top down so the lowest set index is the last one
    // written and therefore the one returned. At most 31 sources exist,
    // so a 5-bit ID always fits.
    function automatic logic [4:0] prio_id(input logic [31:0] elig);
        logic [4:0] id;
        id = 5'd0;
        for (int i = 30; i >= 0; i--) begin
            if (elig[i]) begin
                id = 5'(i + 1);
            end
        end
        return id;
    endfunction

endpackage

// File: rtl/ext_intr_ctrl_if.sv
// ---------------------------------------------------------------------------
// ext_intr_ctrl_if
// Register-bus and core-handshake signals of the external interrupt
// controller.
//   cfg_we / cfg_addr / cfg_wdata : register write port (master drives)
//   cfg_rdata                     : combinational register read data
//   intr / intr_id / busy         : request, in-flight ID, activity flag
//   cu_intr_ack / intr_done       : claim acknowledge and mret completion
// Modports: master = core/bus side, slave = controller side.
// Parameter IDW must match the controller's ID width.
// ---------------------------------------------------------------------------
interface ext_intr_ctrl_if #(
    parameter int IDW = 4
);

    logic           cfg_we;
    logic [1:0]     cfg_addr;
    logic [31:0]    cfg_wdata;
    logic [31:0]    cfg_rdata;
    logic           intr;
    logic           cu_intr_ack;
    logic           intr_done;
    logic [IDW-1:0] intr_id;
    logic           busy;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, cu_intr_ack, intr_done,
        input  cfg_rdata, intr, intr_id, busy
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, cu_intr_ack, intr_done,
        output cfg_rdata, intr, intr_id, busy
    );

endinterface

// File: rtl/intr_sync.sv
// ---------------------------------------------------------------------------
// intr_sync
// Two-flop synchroniser for one asynchronous interrupt line.
//   clk, reset : core clock, async active-high reset
//   async_in   : raw device line
//   level      : synchronised level
//   rise       : one-cycle pulse on a synchronised 0->1 transition
//                (present only when INTR_EDGE_EN is defined)
// ---------------------------------------------------------------------------
module intr_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic level
`ifdef INTR_EDGE_EN
    ,
    output logic rise
`endif
);

    logic meta;
    logic stable;

    // Classic two-stage synchroniser; only 'stable' is safe to use.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta   <= 1'b0;
            stable <= 1'b0;
        end else begin
            meta   <= async_in;
            stable <= meta;
        end
    end

    assign level = stable;

`ifdef INTR_EDGE_EN
    logic stable_d;

    // Delayed copy of the synchronised level for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_d <= 1'b0;
        end else begin
            stable_d <= stable;
        end
    end

    assign rise = stable & ~stable_d;
`endif

endmodule

// File: rtl/ext_intr_ctrl.sv
// ---------------------------------------------------------------------------
// ext_intr_ctrl
// External interrupt controller: synchronises NSRC device lines, latches
// them into PENDING, masks with ENABLE, arbitrates (lowest index wins) and
// runs the intr / cu_intr_ack / intr_done handshake with the core.
//   clk, reset : core clock, async active-high reset
//   irq_src    : raw asynchronous device interrupt lines
//   bus        : ext_intr_ctrl_if.slave (register port + core handshake)
// Build option: INTR_EDGE_EN defined selects edge mode (pending bits set on
// rising edges, cleared by claim-ack or W1C); undefined selects level mode
// (pending mirrors the synchronised level).
// ---------------------------------------------------------------------------
module ext_intr_ctrl
    import intr_pkg::*;
#(
    parameter int NSRC = 8,
    parameter int IDW  = $clog2(NSRC + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NSRC-1:0]   irq_src,
    ext_intr_ctrl_if.slave    bus
);

    logic [NSRC-1:0] level_vec;
    logic [NSRC-1:0] en;
    logic [NSRC-1:0] pend;
    logic [NSRC-1:0] elig;
    logic [IDW-1:0]  win_id;
    logic [IDW-1:0]  id_q;
    logic            intr_q;
    logic            busy_q;
    logic            ack_fire;
    logic            done_fire;
    logic [31:0]     rdata;
    state_t          state;

`ifdef INTR_EDGE_EN
    logic [NSRC-1:0] rise_vec;
    logic [NSRC-1:0] ack_clr;
    logic [NSRC-1:0] w1c_clr;
`endif

    // One synchroniser per source line.
    for (genvar i = 0; i < NSRC; i++) begin : g_sync
        intr_sync u_sync (
            .clk      (clk),
            .reset    (reset),
            .async_in (irq_src[i]),
            .level    (level_vec[i])
`ifdef INTR_EDGE_EN
            ,
            .rise     (rise_vec[i])
`endif
        );
    end

    assign elig      = pend & en;
    assign win_id    = IDW'(prio_id(32'(elig)));
    assign ack_fire  = (state == ST_REQ) && bus.cu_intr_ack;
    assign done_fire = (state == ST_SERV) && bus.intr_done;

    // ENABLE register: plain load of the low NSRC bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en <= '0;
        end else if (bus.cfg_we && (bus.cfg_addr == ADDR_ENABLE)) begin
            en <= bus.cfg_wdata[NSRC-1:0];
        end
    end

`ifdef INTR_EDGE_EN
    // Only the bit of the claimed source is cleared by the ack.
    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (ack_fire && (id_q == IDW'(i + 1))) begin
                ack_clr[i] = 1'b1;
            end
        end
    end

    assign w1c_clr = (bus.cfg_we && (bus.cfg_addr == ADDR_PENDING))
                     ? bus.cfg_wdata[NSRC-1:0] : '0;

    // Clears are applied first and the hardware set OR-ed in last, so a
    // new edge in the same cycle as an ack or W1C is never lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~(ack_clr | w1c_clr)) | rise_vec;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{bus.cfg_wdata[31:NSRC], level_vec};
`else
    // Level mode: pending simply tracks the synchronised lines.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend <= '0;
        end else begin
            pend <= level_vec;
        end
    end

    logic unused_bits;
    assign unused_bits = ^bus.cfg_wdata[31:NSRC];
`endif

    // Request/claim FSM with registered intr, intr_id and busy. The ID is
    // latched on leaving IDLE and held until completion, so later changes
    // to ENABLE or PENDING never retarget or retract a request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            intr_q <= 1'b0;
            busy_q <= 1'b0;
            id_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|elig) begin
                        state  <= ST_REQ;
                        intr_q <= 1'b1;
                        busy_q <= 1'b1;
                        id_q   <= win_id;
                    end
                end
                ST_REQ: begin
                    if (ack_fire) begin
                        state  <= ST_SERV;
                        intr_q <= 1'b0;
                    end
                end
                ST_SERV: begin
                    if (done_fire) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                        id_q   <= '0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    intr_q <= 1'b0;
                    busy_q <= 1'b0;
                    id_q   <= '0;
                end
            endcase
        end
    end

    // Register read mux; unimplemented bits and the reserved address read 0.
    always_comb begin
        rdata = '0;
        case (bus.cfg_addr)
            ADDR_ENABLE:  rdata[NSRC-1:0] = en;
            ADDR_PENDING: rdata[NSRC-1:0] = pend;
            ADDR_CLAIM:   rdata[IDW-1:0]  = id_q;
            default:      rdata = '0;
        endcase
    end

    assign bus.cfg_rdata = rdata;
    assign bus.intr      = intr_q;
    assign bus.intr_id   = id_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_ext_intr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ext_intr_ctrl
// Directed, table-driven bench for ext_intr_ctrl (NSRC = 8). Expectations
// adapt to the build: INTR_EDGE_EN defined selects edge-mode expectations.
// ---------------------------------------------------------------------------
module tb_ext_intr_ctrl;
    import intr_pkg::*;

`ifdef INTR_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [7:0] irq_src;
    int         total;
    int         bad;

    ext_intr_ctrl_if #(.IDW(4)) bus ();

    ext_intr_ctrl #(.NSRC(8), .IDW(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .irq_src (irq_src),
        .bus     (bus)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [1:0]  raddr;
        logic [31:0] exp;
    } reg_vec_t;

    typedef struct {
        logic [7:0] irq;
        logic [7:0] en;
        logic [3:0] id;
    } prio_vec_t;

    reg_vec_t  reg_tab[8];
    prio_vec_t prio_tab[7];

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic cfgWrite(input logic [1:0] addr, input logic [31:0] data);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = addr;
        bus.cfg_wdata = data;
        step(1);
        bus.cfg_we    = 1'b0;
    endtask

    task automatic cfgRead(input logic [1:0] addr, output logic [31:0] data);
        bus.cfg_addr = addr;
        #1;
        data = bus.cfg_rdata;
    endtask

    task automatic pulseAck();
        bus.cu_intr_ack = 1'b1;
        step(1);
        bus.cu_intr_ack = 1'b0;
    endtask

    task automatic pulseDone();
        bus.intr_done = 1'b1;
        step(1);
        bus.intr_done = 1'b0;
    endtask

    // One arbitration vector: raise lines, check latency, winner, ack
    // behaviour on PENDING, then tidy up back to IDLE with nothing pending.
    task automatic applyStimulus(input prio_vec_t v);
        logic [31:0] rd;
        logic [7:0]  bit_m;
        cfgWrite(ADDR_ENABLE, 32'(v.en));
        irq_src = v.irq;
        step(3);
        checkOutput("intr_before_k3", 32'(bus.intr), 32'd0);
        cfgRead(ADDR_PENDING, rd);
        checkOutput("pend_after_k2", rd, 32'(v.irq));
        step(1);
        checkOutput("intr_after_k3", 32'(bus.intr), 32'(v.id != 4'd0));
        checkOutput("intr_id_win", 32'(bus.intr_id), 32'(v.id));
        if (v.id != 4'd0) begin
            bit_m = 8'd1 << (v.id - 4'd1);
            pulseAck();
            checkOutput("intr_after_ack", 32'(bus.intr), 32'd0);
            checkOutput("busy_in_serv", 32'(bus.busy), 32'd1);
            cfgRead(ADDR_PENDING, rd);
            checkOutput("pend_after_ack", rd, 32'(EDGE ? (v.irq & ~bit_m) : v.irq));
        end
        irq_src = 8'h00;
        step(3);
        cfgWrite(ADDR_PENDING, 32'hFF);
        if (v.id != 4'd0) begin
            pulseDone();
            checkOutput("id_after_done", 32'(bus.intr_id), 32'd0);
            checkOutput("busy_after_done", 32'(bus.busy), 32'd0);
        end
        step(1);
        checkOutput("intr_idle", 32'(bus.intr), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        total = 0;
        bad   = 0;

        reg_tab[0] = '{1'b1, ADDR_ENABLE,  32'h0000_00A5, ADDR_ENABLE,  32'hA5};
        reg_tab[1] = '{1'b1, ADDR_ENABLE,  32'hFFFF_FF3C, ADDR_ENABLE,  32'h3C};
        reg_tab[2] = '{1'b1, ADDR_CLAIM,   32'h0000_00FF, ADDR_CLAIM,   32'h0};
        reg_tab[3] = '{1'b0, ADDR_ENABLE,  32'h0,         ADDR_ENABLE,  32'h3C};
        reg_tab[4] = '{1'b1, ADDR_PENDING, 32'h0000_00FF, ADDR_PENDING, 32'h0};
        reg_tab[5] = '{1'b1, 2'd3,         32'h0000_0012, ADDR_ENABLE,  32'h3C};
        reg_tab[6] = '{1'b0, ADDR_ENABLE,  32'h0,         2'd3,         32'h0};
        reg_tab[7] = '{1'b1, ADDR_ENABLE,  32'h0,         ADDR_ENABLE,  32'h0};

        prio_tab[0] = '{8'h01, 8'h01, 4'd1};
        prio_tab[1] = '{8'h24, 8'hFF, 4'd3};
        prio_tab[2] = '{8'h24, 8'hFB, 4'd6};
        prio_tab[3] = '{8'h80, 8'hFF, 4'd8};
        prio_tab[4] = '{8'hF0, 8'h30, 4'd5};
        prio_tab[5] = '{8'h81, 8'h80, 4'd8};
        prio_tab[6] = '{8'h10, 8'h00, 4'd0};

        reset           = 1'b1;
        irq_src         = 8'h00;
        bus.cfg_we      = 1'b0;
        bus.cfg_addr    = 2'd0;
        bus.cfg_wdata   = 32'h0;
        bus.cu_intr_ack = 1'b0;
        bus.intr_done   = 1'b0;
        step(3);
        reset = 1'b0;
        step(1);

        // Reset state
        checkOutput("rst_intr", 32'(bus.intr), 32'd0);
        checkOutput("rst_id", 32'(bus.intr_id), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        cfgRead(ADDR_ENABLE, rd);
        checkOutput("rst_enable", rd, 32'd0);
        cfgRead(ADDR_PENDING, rd);
        checkOutput("rst_pending", rd, 32'd0);

        // Register access table
        foreach (reg_tab[i]) begin
            step(1);
            if (reg_tab[i].we) begin
                cfgWrite(reg_tab[i].addr, reg_tab[i].wdata);
            end
            cfgRead(reg_tab[i].raddr, rd);
            checkOutput($sformatf("reg_%0d", i), rd, reg_tab[i].exp);
        end
        step(1);

        // Arbitration table
        foreach (prio_tab[i]) begin
            applyStimulus(prio_tab[i]);
        end

        // Two sources at once: 3 first, then 6 after completion
        cfgWrite(ADDR_ENABLE, 32'hFF);
        irq_src = 8'h24;
        step(4);
        checkOutput("dual_first_id", 32'(bus.intr_id), 32'd3);
        pulseAck();
        irq_src = 8'h20;
        step(3);
        pulseDone();
        checkOutput("dual_idle_id", 32'(bus.intr_id), 32'd0);
        step(1);
        checkOutput("dual_second_intr", 32'(bus.intr), 32'd1);
        checkOutput("dual_second_id", 32'(bus.intr_id), 32'd6);
        pulseAck();
        irq_src = 8'h00;
        step(3);
        cfgWrite(ADDR_PENDING, 32'hFF);
        pulseDone();
        step(2);

        // Late enable: pending while masked, request two edges after write
        cfgWrite(ADDR_ENABLE, 32'h00);
        irq_src = 8'h10;
        step(4);
        cfgRead(ADDR_PENDING, rd);
        checkOutput("masked_pending", rd, 32'h10);
        checkOutput("masked_intr", 32'(bus.intr), 32'd0);
        cfgWrite(ADDR_ENABLE, 32'h10);
        checkOutput("en_plus1_intr", 32'(bus.intr), 32'd0);
        step(1);
        checkOutput("en_plus2_intr", 32'(bus.intr), 32'd1);
        checkOutput("en_plus2_id", 32'(bus.intr_id), 32'd5);
        pulseAck();
        irq_src = 8'h00;
        step(3);
        cfgWrite(ADDR_PENDING, 32'hFF);
        pulseDone();
        step(2);

        // Held line through completion: re-requests only in level mode
        cfgWrite(ADDR_ENABLE, 32'h01);
        irq_src = 8'h01;
        step(4);
        pulseAck();
        pulseDone();
        checkOutput("hold_idle_intr", 32'(bus.intr), 32'd0);
        checkOutput("hold_idle_id", 32'(bus.intr_id), 32'd0);
        step(1);
        checkOutput("hold_rereq_intr", 32'(bus.intr), 32'(!EDGE));
        checkOutput("hold_rereq_id", 32'(bus.intr_id), EDGE ? 32'd0 : 32'd1);
        irq_src = 8'h00;
        if (!EDGE) begin
            pulseAck();
            step(3);
            pulseDone();
        end
        step(3);

`ifdef INTR_EDGE_EN
        // Ack and a new edge of the same source hit pend in one cycle
        irq_src = 8'h01;
        step(4);
        irq_src = 8'h00;
        step(2);
        irq_src = 8'h01;
        step(2);
        pulseAck();
        cfgRead(ADDR_PENDING, rd);
        checkOutput("ack_vs_set_pend", rd, 32'h01);
        irq_src = 8'h00;
        step(1);
        pulseDone();
        step(1);
        checkOutput("ack_vs_set_rereq", 32'(bus.intr), 32'd1);
        checkOutput("ack_vs_set_id", 32'(bus.intr_id), 32'd1);
        pulseAck();
        pulseDone();
        step(3);
`endif

        // Spurious strobes: ack in IDLE, done in REQ
        pulseAck();
        checkOutput("spur_ack_busy", 32'(bus.busy), 32'd0);
        checkOutput("spur_ack_intr", 32'(bus.intr), 32'd0);
        irq_src = 8'h01;
        step(4);
        pulseDone();
        checkOutput("spur_done_intr", 32'(bus.intr), 32'd1);
        checkOutput("spur_done_busy", 32'(bus.busy), 32'd1);
        checkOutput("spur_done_id", 32'(bus.intr_id), 32'd1);

        // Reset while in SERV
        pulseAck();
        checkOutput("serv_busy", 32'(bus.busy), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("rst_serv_intr", 32'(bus.intr), 32'd0);
        checkOutput("rst_serv_id", 32'(bus.intr_id), 32'd0);
        checkOutput("rst_serv_busy", 32'(bus.busy), 32'd0);
        cfgRead(ADDR_PENDING, rd);
        checkOutput("rst_serv_pend", rd, 32'd0);
        irq_src = 8'h00;
        step(3);
        reset = 1'b0;
        step(2);
        cfgRead(ADDR_ENABLE, rd);
        checkOutput("rst_serv_enable", rd, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
